fadd_norm_round: RTL and testbench

Normalize-and-round back end for the FP16 adder (1 sign, 5-bit exponent with bias 15, 10-bit fraction). It consumes the raw sign, exponent and extended mantissa (carry, hidden, fraction, guard/round/sticky) produced by the align/add stage. It emits a packed IEEE half-precision result with round-to-nearest-even. Normalization is iterative, one bit per cycle, under a valid/ready handshake on both sides.

---
 rtl/fadd_norm_round_if.sv | 27 ++
 rtl/fadd_norm_round.sv | 155 +++++++++++++++
 tb/tb_fadd_norm_round.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fadd_norm_round_if.sv
// Handshake bundle between the FP16 align/add stage, the normalize/round back end and the result consumer.
// The slave modport is the back end's view; the master modport is the surrounding environment's view.
interface fadd_norm_round_if #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [FRAC_W+4:0]       in_man;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_sum;
    logic                    out_inexact;
    logic                    out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_sum, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_sum, out_inexact, out_overflow
    );
endinterface

// File: rtl/fadd_norm_round.sv
// FP16 adder back end: iterative one-bit-per-cycle normalization followed by round-to-nearest-even,
// packing sign/exponent/fraction into a half-precision result with inexact and overflow flags.
module fadd_norm_round #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    fadd_norm_round_if.slave      bus
);
    localparam int MW = FRAC_W + 5;
    localparam int SW = EXP_W + FRAC_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_INF  = {EXP_W{1'b1}};
    localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MW-1:0]     man_q, man_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic              inexact_q, inexact_d;
    logic              overflow_q, overflow_d;

    logic [EXP_W:0]    exp_inc_s;
    logic              inc_s;
    logic [FRAC_W+1:0] sig_s;

    function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    // Shared datapath terms: exponent increment and the rounded significand (hidden + fraction).
    assign exp_inc_s = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
    assign inc_s     = rne_inc(man_q[3], man_q[2], man_q[1], man_q[0]);
    assign sig_s     = {1'b0, man_q[MW-2:3]} + {{(FRAC_W+1){1'b0}}, inc_s};

    // Next-state and datapath control for the normalize/round sequence.
    always_comb begin
        logic [EXP_W:0] exp_rnd;
        logic [FRAC_W-1:0] frac_rnd;
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        man_d      = man_q;
        sum_d      = sum_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        exp_rnd    = {1'b0, exp_q};
        frac_rnd   = sig_s[FRAC_W-1:0];
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d     = bus.in_sign;
                    exp_d      = (bus.in_exp == EXP_ZERO) ? EXP_ONE : bus.in_exp;
                    man_d      = bus.in_man;
                    inexact_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_NORM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (man_q == {MW{1'b0}}) begin
                    sum_d   = {sign_q, EXP_ZERO, FRAC_ZERO};
                    state_d = ST_DONE;
                end else if (man_q[MW-1]) begin
                    // Carry-out: fold the dropped bit into sticky; the shifted value cannot carry again.
                    man_d = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
                    if (exp_inc_s == {1'b0, EXP_INF}) begin
                        sum_d      = {sign_q, EXP_INF, FRAC_ZERO};
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        exp_d   = exp_inc_s[EXP_W-1:0];
                        state_d = ST_ROUND;
                    end
                end else if (man_q[MW-2]) begin
                    state_d = ST_ROUND;
                end else if (exp_q > EXP_ONE) begin
                    man_d = {man_q[MW-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end else begin
                    exp_d   = EXP_ZERO;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (sig_s[FRAC_W+1]) begin
                    frac_rnd = FRAC_ZERO;
                    exp_rnd  = exp_inc_s;
                end else if ((exp_q == EXP_ZERO) && sig_s[FRAC_W]) begin
                    exp_rnd = {1'b0, EXP_ONE};
                end else begin
                    exp_rnd = {1'b0, exp_q};
                end
                if (exp_rnd >= {1'b0, EXP_INF}) begin
                    sum_d      = {sign_q, EXP_INF, FRAC_ZERO};
                    overflow_d = 1'b1;
                end else begin
                    sum_d      = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
                    overflow_d = 1'b0;
                end
                inexact_d = man_q[2] | man_q[1] | man_q[0];
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and working registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= EXP_ZERO;
            man_q      <= {MW{1'b0}};
            sum_q      <= {SW{1'b0}};
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            sum_q      <= sum_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.out_sum      = sum_q;
    assign bus.out_inexact  = inexact_q;
    assign bus.out_overflow = overflow_q;
endmodule

// File: tb/tb_fadd_norm_round.sv
// Self-checking bench for fadd_norm_round: directed cases plus randomized operands checked against
// an arithmetic reference model of normalization and round-to-nearest-even.
module tb_fadd_norm_round;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fadd_norm_round_if #(.EXP_W(5), .FRAC_W(10)) bus ();

    fadd_norm_round #(.EXP_W(5), .FRAC_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: value-level normalization then RNE on the 3 bits below the fraction LSB.
    task automatic model(input logic s, input logic [4:0] e_in, input logic [14:0] m_in,
                         output logic [15:0] sum, output logic inex, output logic ovf, output int lat);
        int e, m, q, rem, k;
        e = (e_in == 5'd0) ? 1 : int'(e_in);
        m = int'(m_in);
        inex = 1'b0;
        ovf  = 1'b0;
        if (m == 0) begin
            sum = {s, 15'd0};
            lat = 1;
            return;
        end
        if (m >= 16384) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            if (e == 31) begin
                sum = {s, 5'h1F, 10'd0};
                ovf = 1'b1;
                lat = 1;
                return;
            end
            lat = 2;
        end else begin
            k = 0;
            while (m < 8192 && e > 1) begin
                m = m * 2;
                e = e - 1;
                k = k + 1;
            end
            if (m < 8192) e = 0;
            lat = 2 + k;
        end
        rem = m % 8;
        q   = m / 8;
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e == 0 && q >= 1024) e = 1;
        inex = (rem != 0);
        if (e >= 31) begin
            sum = {s, 5'h1F, 10'd0};
            ovf = 1'b1;
        end else begin
            sum = {s, e[4:0], q[9:0]};
        end
    endtask

    task automatic run_op(input logic s, input logic [4:0] e, input logic [14:0] m,
                          input int hold, input logic poke, output logic [15:0] obs_sum);
        logic [15:0] exp_sum;
        logic        exp_inex, exp_ovf, seen;
        int          exp_lat, lat;
        model(s, e, m, exp_sum, exp_inex, exp_ovf, exp_lat);
        obs_sum = 16'hxxxx;
        @(negedge clk);
        check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_man   = m;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check_eq("valid_seen", 32'(seen), 32'd1);
        if (seen) begin
            obs_sum = bus.out_sum;
            check_eq("sum", 32'(bus.out_sum), 32'(exp_sum));
            check_eq("inexact", 32'(bus.out_inexact), 32'(exp_inex));
            check_eq("overflow", 32'(bus.out_overflow), 32'(exp_ovf));
            check_eq("latency", 32'(lat), 32'(exp_lat));
            for (int i = 0; i < hold; i++) begin
                if (poke) begin
                    bus.in_valid = 1'b1;
                    bus.in_sign  = 1'b1;
                    bus.in_exp   = 5'd20;
                    bus.in_man   = 15'h2000;
                end
                @(posedge clk);
                @(negedge clk);
                check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                check_eq("hold_sum", 32'(bus.out_sum), 32'(exp_sum));
                check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            check_eq("release_valid", 32'(bus.out_valid), 32'd0);
            check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [14:0] rm;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 5'd0;
        bus.in_man    = 15'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check_eq("rst_flags", 32'({bus.out_inexact, bus.out_overflow}), 32'd0);

        run_op(1'b0, 5'd15, 15'h4000, 0, 1'b0, got); check_eq("plan_carry", 32'(got), 32'h4000);
        run_op(1'b0, 5'd15, 15'h200C, 1, 1'b0, got); check_eq("plan_tie_odd", 32'(got), 32'h3C02);
        run_op(1'b0, 5'd15, 15'h2004, 0, 1'b0, got); check_eq("plan_tie_even", 32'(got), 32'h3C00);
        run_op(1'b0, 5'd30, 15'h4000, 0, 1'b0, got); check_eq("plan_ovf_pos", 32'(got), 32'h7C00);
        run_op(1'b1, 5'd30, 15'h4000, 0, 1'b0, got); check_eq("plan_ovf_neg", 32'(got), 32'hFC00);
        run_op(1'b0, 5'd2,  15'h0800, 0, 1'b0, got); check_eq("plan_subnormal", 32'(got), 32'h0200);
        run_op(1'b0, 5'd10, 15'h0000, 4, 1'b1, got); check_eq("plan_zero_bp", 32'(got), 32'h0000);
        run_op(1'b0, 5'd15, 15'h0400, 0, 1'b0, got); check_eq("plan_cancel", 32'(got), 32'h3000);

        // Reset during the second NORM cycle aborts the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 5'd15;
        bus.in_man   = 15'h0400;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("abort_out_sum", 32'(bus.out_sum), 32'd0);
        check_eq("abort_flags", 32'({bus.out_inexact, bus.out_overflow}), 32'd0);
        run_op(1'b0, 5'd15, 15'h2000, 0, 1'b0, got); check_eq("plan_after_abort", 32'(got), 32'h3C00);

        for (int i = 0; i < 300; i++) begin
            rm = 15'($urandom) >> $urandom_range(0, 14);
            run_op(1'($urandom), 5'($urandom_range(0, 30)), rm,
                   int'($urandom_range(0, 2)), 1'($urandom), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
